// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit and receive engines.
package spi_pkg;

   localparam int unsigned SPI_DATA_W = 8;
   localparam int unsigned SPI_DIV_W  = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      DONE  = 3'd4
   } spi_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: half-period counter with registered SCLK and one-cycle
// half-period / rise / fall strobes aligned to the edge that moves SCLK.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int unsigned DIV_W = SPI_DIV_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_run,
   input  logic           i_toggle,
   input  logic [DIV_W:0] i_half,
   output logic           o_sclk,
   output logic           o_half_tick,
   output logic           o_rise_tick,
   output logic           o_fall_tick
);

   localparam logic [DIV_W:0] CNT_ONE = {{DIV_W{1'b0}}, 1'b1};

   logic [DIV_W:0] r_cnt;
   logic           r_sclk;
   logic [DIV_W:0] w_last;
   logic           w_term;

   // One extra counter bit keeps H = divider+1 representable at the maximum divider.
   assign w_last = i_half - CNT_ONE;
   assign w_term = i_run && (r_cnt == w_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else if (!i_run) begin
         r_cnt  <= '0;
         r_sclk <= 1'b0;
      end else begin
         if (w_term) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         if (w_term && i_toggle) begin
            r_sclk <= ~r_sclk;
         end
      end
   end

   assign o_sclk      = r_sclk;
   assign o_half_tick = w_term;
   assign o_rise_tick = w_term && i_toggle && !r_sclk;
   assign o_fall_tick = w_term && i_toggle && r_sclk;

endmodule

// File: rtl/spi_rx.sv
// SPI mode-0 master receive engine: one MSB-first byte per CSN frame,
// shifting tx_wr_data out on MOSI while capturing MISO.
module spi_rx
   import spi_pkg::*;
#(
   parameter int unsigned DIV_W = SPI_DIV_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DIV_W-1:0]      sclk_divider,
   input  logic                  rd_en,
   input  logic [SPI_DATA_W-1:0] tx_wr_data,
   output logic                  rd_done,
   output logic [SPI_DATA_W-1:0] rd_data,
   input  logic                  SPI_miso,
   output logic                  SPI_mosi,
   output logic                  SPI_sclk,
   output logic                  SPI_csn
);

   localparam logic [DIV_W:0] HALF_ONE  = {{DIV_W{1'b0}}, 1'b1};
   localparam logic [3:0]     EDGE_LAST = 4'd15;

   spi_state_t            r_state;
   spi_state_t            w_next;
   logic [DIV_W:0]        r_half;
   logic [SPI_DATA_W-1:0] r_tx_sh;
   logic [SPI_DATA_W-1:0] r_rx_sh;
   logic [SPI_DATA_W-1:0] r_rd_data;
   logic [3:0]            r_edge;
   logic                  r_csn;
   logic                  r_done;

   logic w_run;
   logic w_toggle;
   logic w_start;
   logic w_finish;
   logic w_half_tick;
   logic w_rise;
   logic w_fall;
   logic w_sclk;

   assign w_run    = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
   assign w_toggle = (r_state == SHIFT);

   spi_sclk_gen #(
      .DIV_W (DIV_W)
   ) u_sclk_gen (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_run       (w_run),
      .i_toggle    (w_toggle),
      .i_half      (r_half),
      .o_sclk      (w_sclk),
      .o_half_tick (w_half_tick),
      .o_rise_tick (w_rise),
      .o_fall_tick (w_fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      w_start  = 1'b0;
      w_finish = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (rd_en) begin
               w_start = 1'b1;
               w_next  = SETUP;
            end
         end
         SETUP: begin
            if (w_half_tick) begin
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            // Sixteen half-periods; the last one is the 8th falling edge.
            if (w_half_tick && (r_edge == EDGE_LAST)) begin
               w_next = HOLD;
            end
         end
         HOLD: begin
            if (w_half_tick) begin
               w_finish = 1'b1;
               w_next   = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_edge <= '0;
      end else if (r_state != SHIFT) begin
         r_edge <= '0;
      end else if (w_half_tick) begin
         r_edge <= r_edge + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_half    <= HALF_ONE;
         r_tx_sh   <= '0;
         r_rx_sh   <= '0;
         r_rd_data <= '0;
         r_csn     <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_start) begin
            r_half  <= {1'b0, sclk_divider} + HALF_ONE;
            r_tx_sh <= tx_wr_data;
            r_rx_sh <= '0;
            r_csn   <= 1'b0;
         end
         if (w_fall && (r_edge != EDGE_LAST)) begin
            r_tx_sh <= {r_tx_sh[SPI_DATA_W-2:0], 1'b0};
         end
         if (w_rise) begin
            r_rx_sh <= {r_rx_sh[SPI_DATA_W-2:0], SPI_miso};
         end
         if (w_finish) begin
            r_rd_data <= r_rx_sh;
            r_tx_sh   <= '0;
            r_csn     <= 1'b1;
         end
      end
   end

   assign rd_done  = r_done;
   assign rd_data  = r_rd_data;
   assign SPI_mosi = r_tx_sh[SPI_DATA_W-1];
   assign SPI_sclk = w_sclk;
   assign SPI_csn  = r_csn;

endmodule

// File: tb/tb_spi_rx.sv
// Scoreboard bench for spi_rx: a behavioural SPI slave supplies MISO and
// records MOSI; a monitor pops expected transfers on every rd_done.
module tb_spi_rx;

   localparam int unsigned DIV_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [DIV_W-1:0] sclk_divider = '0;
   logic             rd_en = 1'b0;
   logic [7:0]       tx_wr_data = '0;
   logic             rd_done;
   logic [7:0]       rd_data;
   logic             SPI_miso = 1'b0;
   logic             SPI_mosi;
   logic             SPI_sclk;
   logic             SPI_csn;

   spi_rx #(
      .DIV_W (DIV_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sclk_divider (sclk_divider),
      .rd_en        (rd_en),
      .tx_wr_data   (tx_wr_data),
      .rd_done      (rd_done),
      .rd_data      (rd_data),
      .SPI_miso     (SPI_miso),
      .SPI_mosi     (SPI_mosi),
      .SPI_sclk     (SPI_sclk),
      .SPI_csn      (SPI_csn)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  rx;
      logic [7:0]  tx;
      int unsigned h;
      int unsigned done_cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  slave_q[$];
   int unsigned checks = 0;
   int unsigned passes = 0;
   int unsigned cyc = 0;

   logic [7:0]  sl_byte = '0;
   logic [7:0]  sl_mosi = '0;
   int          sl_idx = 0;
   int unsigned sl_rises = 0;
   int unsigned sl_high = 0;
   int unsigned frames = 0;
   int unsigned csn_gap = 0;
   logic        prev_csn = 1'b1;
   logic        prev_sclk = 1'b0;
   logic        prev_done = 1'b0;
   exp_t        mon_e;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act == req) passes++;
      else $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
                    name, act, act, req, req, cyc);
   endtask

   // Slave model and scoreboard monitor, sampled 1 ns after each rising edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (!SPI_csn && prev_csn) begin
         if (frames > 0) chk("csn_gap_ge1", longint'(csn_gap >= 1), 1);
         frames++;
         csn_gap  = 0;
         sl_byte  = (slave_q.size() != 0) ? slave_q.pop_front() : 8'($urandom);
         sl_idx   = 7;
         SPI_miso = sl_byte[7];
         sl_mosi  = '0;
         sl_rises = 0;
         sl_high  = 0;
      end
      if (SPI_csn) csn_gap++;
      if (!SPI_csn) begin
         if (SPI_sclk) sl_high++;
         if (SPI_sclk && !prev_sclk) begin
            sl_mosi = {sl_mosi[6:0], SPI_mosi};
            sl_rises++;
         end
         if (!SPI_sclk && prev_sclk && sl_idx > 0) begin
            sl_idx--;
            SPI_miso = sl_byte[sl_idx];
         end
      end
      if (prev_done) chk("done_one_cycle", rd_done, 0);
      if (rd_done) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_done: rd_done=1 with no pending transfer at cycle %0d, required 0", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rd_data", rd_data, mon_e.rx);
            chk("done_cycle", cyc, mon_e.done_cyc);
            chk("mosi_byte", sl_mosi, mon_e.tx);
            chk("sclk_rises", sl_rises, 8);
            chk("sclk_high_cycles", sl_high, 8 * mon_e.h);
         end
      end
      prev_done = rd_done;
      prev_csn  = SPI_csn;
      prev_sclk = SPI_sclk;
   end

   task automatic issue(input logic [7:0] div, input logic [7:0] rx, input logic [7:0] tx,
                        input bit expect_done, output int unsigned n0);
      exp_t e;
      @(negedge clk);
      sclk_divider = div;
      tx_wr_data   = tx;
      rd_en        = 1'b1;
      n0           = cyc;
      slave_q.push_back(rx);
      if (expect_done) begin
         e.rx       = rx;
         e.tx       = tx;
         e.h        = int'(div) + 1;
         e.done_cyc = n0 + 18 * e.h + 1;
         exp_q.push_back(e);
      end
      @(negedge clk);
      rd_en        = 1'b0;
      sclk_divider = 8'($urandom);
      tx_wr_data   = 8'($urandom);
   endtask

   task automatic wait_idle(input int unsigned budget);
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL timeout: %0d transfers still pending after %0d cycles, required 0", exp_q.size(), budget);
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned n0;
      int unsigned f0;
      exp_t        e;
      repeat (3) @(negedge clk);
      chk("reset_csn", SPI_csn, 1);
      chk("reset_sclk", SPI_sclk, 0);
      chk("reset_mosi", SPI_mosi, 0);
      chk("reset_done", rd_done, 0);
      chk("reset_rd_data", rd_data, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      issue(8'd0, 8'hA5, 8'h00, 1'b1, n0);
      wait_idle(100);
      issue(8'd3, 8'h3C, 8'h96, 1'b1, n0);
      wait_idle(200);

      // Requests mid-transfer and during DONE must be ignored.
      f0 = frames;
      issue(8'd2, 8'hC3, 8'h11, 1'b1, n0);
      repeat (5) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      while (cyc < n0 + 18 * 3 + 1) @(negedge clk);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      repeat (60) @(negedge clk);
      chk("ignored_rd_en_frames", frames, f0 + 1);
      chk("ignored_rd_en_rd_data", rd_data, 8'hC3);
      chk("ignored_rd_en_pending", exp_q.size(), 0);

      // Reset after the 4th SCLK rise aborts the frame.
      issue(8'd2, 8'h77, 8'h24, 1'b0, n0);
      while (cyc < n0 + 8 * 3 + 1) @(negedge clk);
      chk("rises_before_reset", sl_rises, 4);
      rst_n = 1'b0;
      #1;
      chk("abort_csn", SPI_csn, 1);
      chk("abort_sclk", SPI_sclk, 0);
      chk("abort_rd_data", rd_data, 0);
      chk("abort_done", rd_done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      issue(8'($urandom_range(0, 3)), 8'h5A, 8'($urandom), 1'b1, n0);
      wait_idle(200);

      // rd_en held high: back-to-back frames start the cycle after DONE.
      @(negedge clk);
      sclk_divider = 8'd1;
      tx_wr_data   = 8'hC9;
      rd_en        = 1'b1;
      n0           = cyc;
      slave_q.push_back(8'hFF);
      slave_q.push_back(8'h00);
      e.rx = 8'hFF; e.tx = 8'hC9; e.h = 2; e.done_cyc = n0 + 37;
      exp_q.push_back(e);
      e.rx = 8'h00; e.done_cyc = n0 + 37 + 38;
      exp_q.push_back(e);
      while (cyc < n0 + 45) @(negedge clk);
      rd_en = 1'b0;
      wait_idle(200);

      issue(8'd255, 8'hFF, 8'($urandom), 1'b1, n0);
      wait_idle(5000);

      for (int i = 0; i < 10; i++) begin
         issue(8'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b1, n0);
         wait_idle(300);
      end

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
